noc_stream_arbiter: RTL and testbench



---
 rtl/noc_arb_pkg.sv | 26 ++
 rtl/noc_axis_skid.sv | 85 ++++++++
 rtl/noc_stream_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_noc_stream_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package : noc_arb_pkg
// Brief   : Shared types and constants for the tile NoC egress stream arbiter.
// Rev     : 1.0
// ============================================================================
package noc_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_PASS  = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int SRC_NOC  = 0;
    localparam int SRC_SPY  = 1;
    localparam int SRC_MEM  = 2;
    localparam int SRC_PCPI = 3;

    localparam int CNT_W = 17;

endpackage
`default_nettype wire

// File: rtl/noc_axis_skid.sv
`default_nettype none
// ============================================================================
// Module : noc_axis_skid
// Brief  : Two-entry AXI-Stream register slice; in_ready is a pure flop output.
// Rev    : 1.0
// ============================================================================
module noc_axis_skid #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [DATA_W/8-1:0] in_keep,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [DATA_W/8-1:0] out_keep,
    output logic                out_last
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int PAY_W  = DATA_W + KEEP_W + 1;

    logic [PAY_W-1:0] out_pay_q, out_pay_d;
    logic [PAY_W-1:0] skid_pay_q, skid_pay_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [PAY_W-1:0] in_pay;
    logic             in_fire;
    logic             out_free;

    assign in_pay   = {in_last, in_keep, in_data};
    assign in_fire  = in_valid & in_ready_q;
    assign out_free = ~out_valid_q | out_ready;

    always_comb begin
        out_pay_d    = out_pay_q;
        skid_pay_d   = skid_pay_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_pay_d    = skid_pay_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_pay_d = in_pay;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_pay_d   = in_pay;
        end
        // Ready next cycle only if the skid entry will be empty.
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pay_q    <= '0;
            skid_pay_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_pay_q    <= out_pay_d;
            skid_pay_q   <= skid_pay_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready                         = in_ready_q;
    assign out_valid                        = out_valid_q;
    assign {out_last, out_keep, out_data}   = out_pay_q;

endmodule
`default_nettype wire

// File: rtl/noc_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module : noc_stream_arbiter
// Brief  : N-source AXI-Stream packet arbiter with beat watchdog and skid output.
// Rev    : 1.0
// ============================================================================
module noc_stream_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int DATA_W    = 32,
    parameter int ARB_MODE  = 0,
    parameter int MAX_BEATS = 256
) (
    input  logic                        clk_line,
    input  logic                        clk_line_rst_high,
    input  logic [NUM_SRC-1:0]          stream_in_TVALID,
    output logic [NUM_SRC-1:0]          stream_in_TREADY,
    input  logic [NUM_SRC*DATA_W-1:0]   stream_in_TDATA,
    input  logic [NUM_SRC*DATA_W/8-1:0] stream_in_TKEEP,
    input  logic [NUM_SRC-1:0]          stream_in_TLAST,
    output logic                        stream_out_TVALID,
    input  logic                        stream_out_TREADY,
    output logic [DATA_W-1:0]           stream_out_TDATA,
    output logic [DATA_W/8-1:0]         stream_out_TKEEP,
    output logic                        stream_out_TLAST,
    output logic [NUM_SRC-1:0]          grant,
    output logic                        err_trunc
);

    localparam int               KEEP_W  = DATA_W / 8;
    localparam int               PTR_W   = $clog2(NUM_SRC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    arb_state_e         state_q, state_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               err_trunc_q, err_trunc_d;

    logic [PTR_W-1:0]   arb_base, win_idx, sel_idx;
    logic               win_found;
    logic [NUM_SRC-1:0] win_oh, owner_oh, ready;
    logic               sel_last, fire, beat_is_max, trunc;
    logic [DATA_W-1:0]  sel_data;
    logic [KEEP_W-1:0]  sel_keep;
    logic               slice_ready, slice_in_valid, slice_in_last;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_SRC) begin
            s = s - NUM_SRC;
        end
        return PTR_W'(s);
    endfunction

    assign arb_base = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;

    // First valid source scanning upward from arb_base with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!win_found && stream_in_TVALID[wrap_add(arb_base, k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(arb_base, k);
            end
        end
    end

    assign win_oh   = win_found ? (NUM_SRC'(1) << win_idx) : '0;
    assign owner_oh = NUM_SRC'(1) << owner_q;
    assign sel_idx  = (state_q == ARB_IDLE) ? win_idx : owner_q;
    assign sel_last = stream_in_TLAST[sel_idx];
    assign sel_data = stream_in_TDATA[sel_idx*DATA_W +: DATA_W];
    assign sel_keep = stream_in_TKEEP[sel_idx*KEEP_W +: KEEP_W];

    always_comb begin
        ready = '0;
        case (state_q)
            ARB_IDLE:  ready = slice_ready ? win_oh : '0;
            ARB_PASS:  ready = slice_ready ? owner_oh : '0;
            ARB_DRAIN: ready = owner_oh;
            default:   ready = '0;
        endcase
    end

    assign fire        = |(stream_in_TVALID & ready);
    assign beat_is_max = (MAX_BEATS != 0) && ((32'(cnt_q) + 32'd1) == 32'(MAX_BEATS));
    assign trunc       = fire & (state_q != ARB_DRAIN) & beat_is_max & ~sel_last;
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    assign slice_in_valid = fire & (state_q != ARB_DRAIN);
    assign slice_in_last  = sel_last | trunc;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        err_trunc_d = trunc;
        case (state_q)
            ARB_IDLE: begin
                if (fire) begin
                    owner_d = win_idx;
                    if (trunc) begin
                        state_d = ARB_DRAIN;
                        cnt_d   = cnt_inc;
                    end else if (sel_last) begin
                        rr_ptr_d = wrap_add(win_idx, 1);
                    end else begin
                        state_d = ARB_PASS;
                        cnt_d   = cnt_inc;
                    end
                end
            end
            ARB_PASS: begin
                if (fire) begin
                    cnt_d = cnt_inc;
                    if (trunc) begin
                        state_d = ARB_DRAIN;
                    end else if (sel_last) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = wrap_add(owner_q, 1);
                        cnt_d    = '0;
                    end
                end
            end
            ARB_DRAIN: begin
                if (fire) begin
                    cnt_d = cnt_inc;
                    if (sel_last) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = wrap_add(owner_q, 1);
                        cnt_d    = '0;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
        if (clk_line_rst_high) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            err_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            err_trunc_q <= err_trunc_d;
        end
    end

    noc_axis_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk_line),
        .rst       (clk_line_rst_high),
        .in_valid  (slice_in_valid),
        .in_ready  (slice_ready),
        .in_data   (sel_data),
        .in_keep   (sel_keep),
        .in_last   (slice_in_last),
        .out_valid (stream_out_TVALID),
        .out_ready (stream_out_TREADY),
        .out_data  (stream_out_TDATA),
        .out_keep  (stream_out_TKEEP),
        .out_last  (stream_out_TLAST)
    );

    assign stream_in_TREADY = ready;
    assign grant            = (state_q == ARB_IDLE) ? '0 : owner_oh;
    assign err_trunc        = err_trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_noc_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_noc_stream_arbiter
// Brief  : Directed bench for noc_stream_arbiter (fixed/watchdog and round-robin).
// Rev    : 1.0
// ============================================================================
module tb_noc_stream_arbiter;
    import noc_arb_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid, in_last;
    logic [127:0] in_data;
    logic [15:0]  in_keep;
    logic         out_ready;

    logic [3:0]   f_tready, f_grant, r_tready, r_grant;
    logic         f_ovalid, f_olast, f_err, r_ovalid, r_olast, r_err;
    logic [31:0]  f_odata, r_odata;
    logic [3:0]   f_okeep, r_okeep;

    always #5 clk = ~clk;

    noc_stream_arbiter #(.NUM_SRC(4), .DATA_W(32), .ARB_MODE(ARB_FIXED), .MAX_BEATS(4)) u_dut_fx (
        .clk_line(clk), .clk_line_rst_high(rst),
        .stream_in_TVALID(in_valid), .stream_in_TREADY(f_tready), .stream_in_TDATA(in_data),
        .stream_in_TKEEP(in_keep), .stream_in_TLAST(in_last),
        .stream_out_TVALID(f_ovalid), .stream_out_TREADY(out_ready), .stream_out_TDATA(f_odata),
        .stream_out_TKEEP(f_okeep), .stream_out_TLAST(f_olast),
        .grant(f_grant), .err_trunc(f_err));

    noc_stream_arbiter #(.NUM_SRC(4), .DATA_W(32), .ARB_MODE(ARB_RR), .MAX_BEATS(256)) u_dut_rr (
        .clk_line(clk), .clk_line_rst_high(rst),
        .stream_in_TVALID(in_valid), .stream_in_TREADY(r_tready), .stream_in_TDATA(in_data),
        .stream_in_TKEEP(in_keep), .stream_in_TLAST(in_last),
        .stream_out_TVALID(r_ovalid), .stream_out_TREADY(out_ready), .stream_out_TDATA(r_odata),
        .stream_out_TKEEP(r_okeep), .stream_out_TLAST(r_olast),
        .grant(r_grant), .err_trunc(r_err));

    int checks = 0;
    int errors = 0;

    // Source model state
    int          rem[4], npk[4], plen[4], sent[4];
    logic [31:0] base[4];
    logic [3:0]  lkeep[4];
    logic        hold[4];
    logic        use_rr;

    // Output monitors
    logic [36:0] qf[$], qr[$], exp_q[$];
    int          qf_cyc[$];
    logic [3:0]  glog[$];
    logic [3:0]  prev_grant;
    int          f_err_cnt;
    int          cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (f_ovalid && out_ready) begin
                qf.push_back({f_olast, f_okeep, f_odata});
                qf_cyc.push_back(cyc);
            end
            if (r_ovalid && out_ready) qr.push_back({r_olast, r_okeep, r_odata});
            if (f_err) f_err_cnt = f_err_cnt + 1;
            if (f_grant != prev_grant && f_grant != 4'b0) glog.push_back(f_grant);
            prev_grant = f_grant;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [36:0] mk(input logic l, input logic [3:0] k, input logic [31:0] d);
        return {l, k, d};
    endfunction

    function automatic logic busy();
        logic b = 1'b0;
        for (int i = 0; i < 4; i++) if (rem[i] > 0 || npk[i] > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            in_valid[i]         = (rem[i] > 0) && !hold[i];
            in_data[i*32 +: 32] = base[i] + 32'(sent[i]);
            in_last[i]          = (rem[i] == 1);
            in_keep[i*4 +: 4]   = (rem[i] == 1) ? lkeep[i] : 4'hF;
        end
    endtask

    task automatic cycle();
        logic [3:0] acc;
        acc = in_valid & (use_rr ? r_tready : f_tready);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                sent[i]++;
                rem[i]--;
                if (rem[i] == 0 && npk[i] > 0) begin
                    rem[i] = plen[i];
                    npk[i]--;
                end
            end
        end
        drive();
        #1;
    endtask

    task automatic clear_src();
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0; npk[i] = 0; plen[i] = 0; sent[i] = 0;
            base[i] = 32'h0; lkeep[i] = 4'hF; hold[i] = 1'b0;
        end
        drive();
    endtask

    task automatic clear_mon();
        qf.delete(); qr.delete(); qf_cyc.delete(); glog.delete(); exp_q.delete();
        prev_grant = 4'b0;
        f_err_cnt  = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        out_ready = 1'b1;
        clear_src();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
        #1;
    endtask

    task automatic run_drain(input string tag);
        for (int c = 0; c < 60 && busy(); c++) cycle();
        chk({tag, "_done"}, 64'(busy()), 64'd0);
        out_ready = 1'b1;
        repeat (4) cycle();
    endtask

    task automatic check_q(input string tag, input logic use_r);
        logic [36:0] o;
        chk({tag, "_n"}, 64'(use_r ? qr.size() : qf.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (use_r) o = (k < qr.size()) ? qr[k] : '1;
            else       o = (k < qf.size()) ? qf[k] : '1;
            chk($sformatf("%s[%0d]", tag, k), 64'(o), 64'(exp_q[k]));
        end
    endtask

    initial begin
        use_rr    = 1'b0;
        rst       = 1'b1;
        out_ready = 1'b1;
        clear_src();
        clear_mon();
        for (int i = 0; i < 4; i++) rem[i] = 1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        // Reset state with all sources requesting
        chk("rst_tready", 64'(f_tready), 64'h0);
        chk("rst_ovalid", 64'(f_ovalid), 64'h0);
        chk("rst_odata",  64'(f_odata),  64'h0);
        chk("rst_okeep",  64'(f_okeep),  64'h0);
        chk("rst_grant",  64'(f_grant),  64'h0);
        chk("rst_err",    64'(f_err),    64'h0);
        chk("rst_rr_tready", 64'(r_tready), 64'h0);

        // Fixed priority: 0 before 3, back to back
        use_rr = 1'b0;
        do_reset();
        rem[SRC_NOC] = 3;  base[SRC_NOC] = 32'h100;
        rem[SRC_PCPI] = 3; base[SRC_PCPI] = 32'h300;
        drive(); #1;
        run_drain("fix");
        exp_q.push_back(mk(1'b0, 4'hF, 32'h100));
        exp_q.push_back(mk(1'b0, 4'hF, 32'h101));
        exp_q.push_back(mk(1'b1, 4'hF, 32'h102));
        exp_q.push_back(mk(1'b0, 4'hF, 32'h300));
        exp_q.push_back(mk(1'b0, 4'hF, 32'h301));
        exp_q.push_back(mk(1'b1, 4'hF, 32'h302));
        check_q("fix_out", 1'b0);
        chk("fix_gap", 64'((qf_cyc.size() == 6) ? (qf_cyc[5] - qf_cyc[0]) : -1), 64'd5);
        chk("fix_glog_n", 64'(glog.size()), 64'd2);
        chk("fix_grant0", 64'((glog.size() > 0) ? glog[0] : 4'hF), 64'h1);
        chk("fix_grant1", 64'((glog.size() > 1) ? glog[1] : 4'hF), 64'h8);

        // Round robin: all sources, single-beat packets, two each
        use_rr = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            base[i] = 32'(i) * 32'h100; plen[i] = 1; rem[i] = 1; npk[i] = 1;
        end
        drive(); #1;
        run_drain("rr");
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b1, 4'hF, 32'(i) * 32'h100 + 32'(p)));
        check_q("rr_out", 1'b1);

        // Backpressure on a 4-beat packet
        use_rr = 1'b0;
        do_reset();
        rem[SRC_SPY] = 4; base[SRC_SPY] = 32'hA0; lkeep[SRC_SPY] = 4'h3;
        drive(); #1;
        begin
            logic [6:0] pat;
            pat = 7'b1010011;
            for (int k = 0; k < 7; k++) begin
                out_ready = pat[k];
                cycle();
            end
        end
        run_drain("bp");
        exp_q.push_back(mk(1'b0, 4'hF, 32'hA0));
        exp_q.push_back(mk(1'b0, 4'hF, 32'hA1));
        exp_q.push_back(mk(1'b0, 4'hF, 32'hA2));
        exp_q.push_back(mk(1'b1, 4'h3, 32'hA3));
        check_q("bp_out", 1'b0);
        chk("bp_idle_valid", 64'(f_ovalid), 64'd0);

        // Watchdog: 6-beat packet truncated at beat 4
        do_reset();
        rem[SRC_SPY] = 6; base[SRC_SPY] = 32'h10;
        drive(); #1;
        run_drain("wd");
        exp_q.push_back(mk(1'b0, 4'hF, 32'h10));
        exp_q.push_back(mk(1'b0, 4'hF, 32'h11));
        exp_q.push_back(mk(1'b0, 4'hF, 32'h12));
        exp_q.push_back(mk(1'b1, 4'hF, 32'h13));
        check_q("wd_out", 1'b0);
        chk("wd_err_cnt", 64'(f_err_cnt), 64'd1);
        chk("wd_consumed", 64'(sent[SRC_SPY]), 64'd6);
        chk("wd_grant_idle", 64'(f_grant), 64'h0);

        // Owner stalls mid-packet while a higher-priority source waits
        do_reset();
        rem[SRC_MEM] = 4; base[SRC_MEM] = 32'h20;
        drive(); #1;
        for (int c = 0; c < 20 && sent[SRC_MEM] < 2; c++) cycle();
        chk("stall_started", 64'(sent[SRC_MEM]), 64'd2);
        hold[SRC_MEM] = 1'b1;
        rem[SRC_NOC] = 1; base[SRC_NOC] = 32'h50;
        drive(); #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall_grant%0d", c), 64'(f_grant), 64'h4);
            chk($sformatf("stall_rdy0_%0d", c), 64'(f_tready[SRC_NOC]), 64'd0);
            cycle();
        end
        hold[SRC_MEM] = 1'b0;
        drive(); #1;
        run_drain("stall");
        exp_q.push_back(mk(1'b0, 4'hF, 32'h20));
        exp_q.push_back(mk(1'b0, 4'hF, 32'h21));
        exp_q.push_back(mk(1'b0, 4'hF, 32'h22));
        exp_q.push_back(mk(1'b1, 4'hF, 32'h23));
        exp_q.push_back(mk(1'b1, 4'hF, 32'h50));
        check_q("stall_out", 1'b0);

        // Asynchronous reset in the middle of a packet
        do_reset();
        rem[SRC_PCPI] = 4; base[SRC_PCPI] = 32'h30;
        drive(); #1;
        for (int c = 0; c < 20 && sent[SRC_PCPI] < 2; c++) cycle();
        chk("mid_started", 64'(f_grant), 64'h8);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_ovalid", 64'(f_ovalid), 64'd0);
        chk("mid_odata",  64'(f_odata),  64'h0);
        chk("mid_olast",  64'(f_olast),  64'd0);
        chk("mid_okeep",  64'(f_okeep),  64'h0);
        chk("mid_grant",  64'(f_grant),  64'h0);
        chk("mid_tready", 64'(f_tready), 64'h0);
        @(posedge clk);
        #1;
        clear_src();
        rst = 1'b0;
        clear_mon();
        rem[SRC_PCPI] = 2; base[SRC_PCPI] = 32'h30;
        rem[SRC_SPY]  = 1; base[SRC_SPY]  = 32'h60;
        drive(); #1;
        run_drain("post");
        exp_q.push_back(mk(1'b1, 4'hF, 32'h60));
        exp_q.push_back(mk(1'b0, 4'hF, 32'h30));
        exp_q.push_back(mk(1'b1, 4'hF, 32'h31));
        check_q("post_out", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
